avalon_pio_edge_ctrl: RTL and testbench

Parametrised Avalon-MM input PIO with per-bit synchroniser, debounce filter, programmable rising/falling edge capture and a maskable interrupt. It sits on the Nios II data master as a memory-mapped slave. It serves external control pins such as push-buttons, DIP switches and board status lines that need glitch rejection and edge-type selection. It supersedes the fixed 4-bit rising-edge input PIO.

---
 rtl/avalon_pio_edge_ctrl_if.sv | 25 ++
 rtl/avalon_pio_edge_ctrl.sv | 157 +++++++++++++++
 tb/tb_avalon_pio_edge_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_pio_edge_ctrl_if.sv
// Avalon-MM slave bus bundle for the edge-capturing input PIO.
// The master drives address/strobes/data; the slave returns registered read data.
interface avalon_pio_edge_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/avalon_pio_edge_ctrl.sv
// Avalon-MM input PIO: per-bit synchroniser and debounce, selectable rising/falling
// edge capture with clear-on-write, and a maskable level interrupt.
module avalon_pio_edge_ctrl #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BIT_CLEAR       = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    avalon_pio_edge_ctrl_if.slave bus,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd5;

    // Set has priority over clear so an edge landing on a clear write is kept.
    function automatic logic [WIDTH-1:0] next_capture(
        input logic [WIDTH-1:0] cap,
        input logic [WIDTH-1:0] set,
        input logic [WIDTH-1:0] clr
    );
        return (cap & ~clr) | set;
    endfunction

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_s;

    logic [WIDTH-1:0]            data_q, data_d;
    logic [WIDTH-1:0]            data_dly_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr_en;
    logic [WIDTH-1:0] rise, fall;
    logic [WIDTH-1:0] clr_bits;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // A new level must be seen DEBOUNCE_CYCLES times in a row; any return
    // to the accepted level restarts the count, so cnt never wraps.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_s[i] == data_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                data_d[i] = sync_s[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            data_dly_q <= '0;
            cnt_q      <= '0;
        end else begin
            data_q     <= data_d;
            data_dly_q <= data_q;
            cnt_q      <= cnt_d;
        end
    end

    assign rise  = data_q & ~data_dly_q & rise_en_q;
    assign fall  = ~data_q & data_dly_q & fall_en_q;
    assign wr_en = bus.chipselect & ~bus.write_n;

    assign clr_bits = (BIT_CLEAR != 0) ? bus.writedata[WIDTH-1:0] : {WIDTH{1'b1}};

    always_comb begin
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        edge_cap_d = next_capture(edge_cap_q, rise | fall, '0);
        if (wr_en) begin
            unique case (bus.address)
                ADDR_IRQ_MASK: irq_mask_d = bus.writedata[WIDTH-1:0];
                ADDR_EDGE_CAP: edge_cap_d = next_capture(edge_cap_q, rise | fall, clr_bits);
                ADDR_RISE_EN:  rise_en_d  = bus.writedata[WIDTH-1:0];
                ADDR_FALL_EN:  fall_en_d  = bus.writedata[WIDTH-1:0];
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
            rise_en_q  <= '1;
            fall_en_q  <= '0;
            edge_cap_q <= '0;
        end else begin
            irq_mask_q <= irq_mask_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            edge_cap_q <= edge_cap_d;
        end
    end

    // Read mux is sampled every edge regardless of chipselect; no read side effects.
    always_comb begin
        readdata_d = '0;
        unique case (bus.address)
            ADDR_DATA:     readdata_d[WIDTH-1:0] = data_q;
            ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
            ADDR_RISE_EN:  readdata_d[WIDTH-1:0] = rise_en_q;
            ADDR_FALL_EN:  readdata_d[WIDTH-1:0] = fall_en_q;
            default:       ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edge_cap_q & irq_mask_q);

    generate
        if (WIDTH < 32) begin : g_wdata_upper
            logic unused_wdata_upper;
            assign unused_wdata_upper = ^bus.writedata[31:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_avalon_pio_edge_ctrl.sv
// Directed bench for avalon_pio_edge_ctrl with default parameters (4 channels,
// 2 sync stages, 4-cycle debounce, write-1-to-clear capture).
module tb_avalon_pio_edge_ctrl;

    logic       clk;
    logic       reset_n;
    logic [3:0] in_port;
    logic       irq;
    int         total;
    int         passed;

    avalon_pio_edge_ctrl_if bus ();

    avalon_pio_edge_ctrl #(
        .WIDTH           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .BIT_CLEAR       (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end right after a falling edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data           = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        in_port        = 4'h0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_rd [6];
        do_reset();
        bus_write(3'd2, 32'h1);
        in_port = 4'h1;
        idle(10);
        total++;
        if (irq !== 1'b1) $display("FAIL reset_pre_irq: got %b expected 1", irq); else passed++;
        bus_read(3'd2, rd);
        total++;
        if (rd !== 32'h1) $display("FAIL reset_pre_mask: got 0x%0h expected 0x1", rd); else passed++;
        #2 reset_n = 1'b0;
        in_port = 4'h0;
        #1;
        total++;
        if (bus.readdata !== 32'h0) $display("FAIL reset_async_readdata: got 0x%0h expected 0x0", bus.readdata); else passed++;
        total++;
        if (irq !== 1'b0) $display("FAIL reset_async_irq: got %b expected 0", irq); else passed++;
        @(negedge clk);
        idle(1);
        reset_n = 1'b1;
        idle(1);
        exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hF, 32'h0};
        for (int a = 0; a < 6; a++) begin
            bus_read(3'(a), rd);
            total++;
            if (rd !== exp_rd[a]) $display("FAIL reset_reg%0d: got 0x%0h expected 0x%0h", a, rd, exp_rd[a]); else passed++;
        end
    endtask

    task automatic test_rise_latency();
        logic [31:0] rd;
        do_reset();
        bus_write(3'd2, 32'h1);
        in_port = 4'h1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (irq !== (k == 7)) $display("FAIL latency_irq_edge%0d: got %b expected %b", k, irq, (k == 7)); else passed++;
        end
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h1) $display("FAIL latency_capture: got 0x%0h expected 0x1", rd); else passed++;
        bus_read(3'd0, rd);
        total++;
        if (rd !== 32'h1) $display("FAIL latency_data: got 0x%0h expected 0x1", rd); else passed++;
    endtask

    task automatic run_pulse(input int n, output logic saw);
        saw            = 1'b0;
        bus.address    = 3'd0;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        in_port        = 4'h4;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == n) in_port = 4'h0;
            if (bus.readdata[2] === 1'b1) saw = 1'b1;
        end
        bus.chipselect = 1'b0;
    endtask

    task automatic test_debounce();
        logic        saw;
        logic [31:0] rd;
        do_reset();
        run_pulse(3, saw);
        total++;
        if (saw !== 1'b0) $display("FAIL debounce3_data_seen: got %b expected 0", saw); else passed++;
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h0) $display("FAIL debounce3_capture: got 0x%0h expected 0x0", rd); else passed++;
        run_pulse(4, saw);
        total++;
        if (saw !== 1'b1) $display("FAIL debounce4_data_seen: got %b expected 1", saw); else passed++;
        bus_read(3'd0, rd);
        total++;
        if (rd !== 32'h0) $display("FAIL debounce4_data_after: got 0x%0h expected 0x0", rd); else passed++;
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h4) $display("FAIL debounce4_capture: got 0x%0h expected 0x4", rd); else passed++;
    endtask

    task automatic test_fall_only();
        logic [31:0] rd;
        do_reset();
        bus_write(3'd4, 32'h0);
        bus_write(3'd5, 32'h2);
        in_port = 4'h2;
        idle(10);
        bus_read(3'd0, rd);
        total++;
        if (rd !== 32'h2) $display("FAIL fall_data_high: got 0x%0h expected 0x2", rd); else passed++;
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h0) $display("FAIL fall_no_rise_capture: got 0x%0h expected 0x0", rd); else passed++;
        in_port = 4'h0;
        idle(10);
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h2) $display("FAIL fall_capture: got 0x%0h expected 0x2", rd); else passed++;
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        do_reset();
        in_port = 4'h5;
        idle(10);
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h5) $display("FAIL w1c_setup: got 0x%0h expected 0x5", rd); else passed++;
        bus_write(3'd3, 32'h0);
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h5) $display("FAIL w1c_zero_write: got 0x%0h expected 0x5", rd); else passed++;
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h4) $display("FAIL w1c_clear_bit0: got 0x%0h expected 0x4", rd); else passed++;
        in_port = 4'h4;
        idle(10);
        in_port = 4'h5;
        idle(6);
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h5) $display("FAIL collision_set_wins: got 0x%0h expected 0x5", rd); else passed++;
    endtask

    task automatic test_mask();
        logic [31:0] rd;
        do_reset();
        in_port = 4'h8;
        idle(10);
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h8) $display("FAIL mask_capture: got 0x%0h expected 0x8", rd); else passed++;
        total++;
        if (irq !== 1'b0) $display("FAIL mask_irq_masked: got %b expected 0", irq); else passed++;
        bus_write(3'd2, 32'h8);
        total++;
        if (irq !== 1'b1) $display("FAIL mask_irq_enabled: got %b expected 1", irq); else passed++;
        bus_write(3'd3, 32'h8);
        total++;
        if (irq !== 1'b0) $display("FAIL mask_irq_cleared: got %b expected 0", irq); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        do_reset();
        bus_write(3'd4, 32'hFFFF_FFFA);
        bus_read(3'd4, rd);
        total++;
        if (rd !== 32'hA) $display("FAIL b2b_rise_en: got 0x%0h expected 0xa", rd); else passed++;
        bus_write(3'd5, 32'h5);
        bus_read(3'd5, rd);
        total++;
        if (rd !== 32'h5) $display("FAIL b2b_fall_en: got 0x%0h expected 0x5", rd); else passed++;
        bus_write(3'd0, 32'hF);
        bus_read(3'd0, rd);
        total++;
        if (rd !== 32'h0) $display("FAIL b2b_data_ro: got 0x%0h expected 0x0", rd); else passed++;
        bus_write(3'd1, 32'hF);
        bus_read(3'd1, rd);
        total++;
        if (rd !== 32'h0) $display("FAIL b2b_addr1: got 0x%0h expected 0x0", rd); else passed++;
        bus_write(3'd6, 32'hF);
        bus_read(3'd2, rd);
        total++;
        if (rd !== 32'h0) $display("FAIL b2b_addr6_ignored: got 0x%0h expected 0x0", rd); else passed++;
    endtask

    initial begin
        total          = 0;
        passed         = 0;
        reset_n        = 1'b0;
        in_port        = 4'h0;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        @(negedge clk);
        test_reset();
        test_rise_latency();
        test_debounce();
        test_fall_only();
        test_w1c_collision();
        test_mask();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
